// File: rtl/efpga_fcb_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : efpga_fcb_apb_bridge
// Brief    : Converts a req/gnt/r_valid slave port into a single-outstanding
//            APB4 master.  Optional ACCESS watchdog: FCB_APB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module efpga_fcb_apb_bridge #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    BYTE_ENABLE_BIT = DATA_WIDTH/8,
  parameter int                    TIMEOUT_CYCLES  = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA       = 32'hDEAD_BEEF
) (
  input  logic                       clk,
  input  logic                       rst_i,
  input  logic                       data_req_i,
  input  logic [ADDR_WIDTH-1:0]      data_add_i,
  input  logic                       data_wen_i,
  input  logic [DATA_WIDTH-1:0]      data_wdata_i,
  input  logic [BYTE_ENABLE_BIT-1:0] data_be_i,
  output logic                       data_gnt_o,
  output logic                       data_r_valid_o,
  output logic [DATA_WIDTH-1:0]      data_r_rdata_o,
  output logic                       data_r_opc_o,
  output logic [ADDR_WIDTH-1:0]      paddr_o,
  output logic [DATA_WIDTH-1:0]      pwdata_o,
  output logic                       pwrite_o,
  output logic [BYTE_ENABLE_BIT-1:0] pstrb_o,
  output logic                       psel_o,
  output logic                       penable_o,
  input  logic [DATA_WIDTH-1:0]      prdata_i,
  input  logic                       pready_i,
  input  logic                       pslverr_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic                       w_gnt;
  logic                       w_access;
  logic                       w_done;
  logic                       w_abort;

  logic [ADDR_WIDTH-1:0]      r_paddr;
  logic [DATA_WIDTH-1:0]      r_pwdata;
  logic                       r_pwrite;
  logic [BYTE_ENABLE_BIT-1:0] r_pstrb;
  logic                       r_psel;
  logic                       r_penable;
  logic                       r_valid;
  logic [DATA_WIDTH-1:0]      r_rdata;
  logic                       r_opc;

  assign w_access = (r_state == S_ACCESS);
  assign w_done   = w_access & pready_i;

`ifdef FCB_APB_TIMEOUT_EN
  localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_wait_cnt;

  // Counter is held at zero outside ACCESS, so it starts from zero on entry.
  always_ff @(posedge clk) begin
    if (rst_i || !w_access) begin
      r_wait_cnt <= '0;
    end else if (!pready_i) begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
    end
  end

  // A late pready_i on the abort cycle still wins over the timeout.
  assign w_abort = w_access & ~pready_i & (r_wait_cnt == c_TIMEOUT_LAST);
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^TIMEOUT_CYCLES;
  assign w_abort      = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_gnt = data_req_i & ~rst_i;
        if (w_gnt) w_state_nxt = S_SETUP;
      end
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_done || w_abort) w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // APB strobes and response flags are decoded from the next state so they
  // change on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pwrite  <= 1'b0;
      r_pstrb   <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_valid   <= 1'b0;
      r_rdata   <= '0;
      r_opc     <= 1'b0;
    end else begin
      r_psel    <= (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
      r_penable <= (w_state_nxt == S_ACCESS);
      r_valid   <= (w_state_nxt == S_RESP);
      if (w_gnt) begin
        r_paddr  <= data_add_i;
        r_pwdata <= data_wdata_i;
        r_pwrite <= ~data_wen_i;
        r_pstrb  <= data_wen_i ? '0 : data_be_i;
      end
      if (w_done) begin
        r_rdata <= r_pwrite ? '0 : prdata_i;
        r_opc   <= pslverr_i;
      end else if (w_abort) begin
        r_rdata <= r_pwrite ? '0 : ERR_RDATA;
        r_opc   <= 1'b1;
      end
    end
  end

  assign data_gnt_o     = w_gnt;
  assign data_r_valid_o = r_valid;
  assign data_r_rdata_o = r_rdata;
  assign data_r_opc_o   = r_opc;
  assign paddr_o        = r_paddr;
  assign pwdata_o       = r_pwdata;
  assign pwrite_o       = r_pwrite;
  assign pstrb_o        = r_pstrb;
  assign psel_o         = r_psel;
  assign penable_o      = r_penable;

endmodule
`default_nettype wire

// File: tb/tb_efpga_fcb_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_efpga_fcb_apb_bridge
// Brief    : Directed + randomized bench for efpga_fcb_apb_bridge with a
//            transaction-level expectation model (FCB_APB_TIMEOUT_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_efpga_fcb_apb_bridge;

  localparam int TMO = 8;

  logic        clk;
  logic        rst_i;
  logic        data_req_i;
  logic [31:0] data_add_i;
  logic        data_wen_i;
  logic [31:0] data_wdata_i;
  logic [3:0]  data_be_i;
  logic        data_gnt_o;
  logic        data_r_valid_o;
  logic [31:0] data_r_rdata_o;
  logic        data_r_opc_o;
  logic [31:0] paddr_o;
  logic [31:0] pwdata_o;
  logic        pwrite_o;
  logic [3:0]  pstrb_o;
  logic        psel_o;
  logic        penable_o;
  logic [31:0] prdata_i;
  logic        pready_i;
  logic        pslverr_i;

  int n_checks = 0;
  int n_err    = 0;
  int n_pulses = 0;
  int exp_pulses = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_opc   = 1'b0;

  efpga_fcb_apb_bridge #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .BYTE_ENABLE_BIT(4),
    .TIMEOUT_CYCLES (TMO),
    .ERR_RDATA      (32'hDEAD_BEEF)
  ) dut (
    .clk           (clk),
    .rst_i         (rst_i),
    .data_req_i    (data_req_i),
    .data_add_i    (data_add_i),
    .data_wen_i    (data_wen_i),
    .data_wdata_i  (data_wdata_i),
    .data_be_i     (data_be_i),
    .data_gnt_o    (data_gnt_o),
    .data_r_valid_o(data_r_valid_o),
    .data_r_rdata_o(data_r_rdata_o),
    .data_r_opc_o  (data_r_opc_o),
    .paddr_o       (paddr_o),
    .pwdata_o      (pwdata_o),
    .pwrite_o      (pwrite_o),
    .pstrb_o       (pstrb_o),
    .psel_o        (psel_o),
    .penable_o     (penable_o),
    .prdata_i      (prdata_i),
    .pready_i      (pready_i),
    .pslverr_i     (pslverr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (data_r_valid_o === 1'b1) n_pulses++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction; ready arrives on ACCESS cycle index 'waits'.
  task automatic do_xfer(input logic [31:0] addr, input logic rd, input logic [31:0] wdata,
                         input logic [3:0] be, input int waits, input logic [31:0] prd,
                         input logic slv, input logic hold);
    logic [31:0] exp_rdata;
    logic        exp_opc;
    logic        abort;
    int          n_acc;
    abort = 1'b0;
    n_acc = waits + 1;
`ifdef FCB_APB_TIMEOUT_EN
    if (waits >= TMO) begin
      abort = 1'b1;
      n_acc = TMO;
    end
`endif
    exp_rdata = !rd ? 32'h0 : (abort ? 32'hDEAD_BEEF : prd);
    exp_opc   = abort ? 1'b1 : slv;

    @(negedge clk);
    data_req_i   = 1'b1;
    data_add_i   = addr;
    data_wen_i   = rd;
    data_wdata_i = wdata;
    data_be_i    = be;
    pready_i     = 1'($urandom);
    prdata_i     = $urandom;
    pslverr_i    = 1'($urandom);
    #1;
    chk("gnt_idle",   data_gnt_o, 1);
    chk("rvalid_idle", data_r_valid_o, 0);
    chk("rdata_hold", data_r_rdata_o, last_rdata);
    chk("opc_hold",   data_r_opc_o, last_opc);
    chk("psel_idle",  psel_o, 0);

    @(negedge clk);
    chk("gnt_setup",  data_gnt_o, 0);
    chk("psel_setup", psel_o, 1);
    chk("pen_setup",  penable_o, 0);
    chk("paddr_setup", paddr_o, addr);
    chk("pwrite_setup", pwrite_o, !rd);
    chk("pwdata_setup", pwdata_o, wdata);
    chk("pstrb_setup", pstrb_o, rd ? 4'h0 : be);
    chk("rvalid_setup", data_r_valid_o, 0);
    data_req_i = hold;
    if (!hold) begin
      data_add_i   = $urandom;
      data_wen_i   = 1'($urandom);
      data_wdata_i = $urandom;
      data_be_i    = 4'($urandom);
    end
    pready_i  = 1'($urandom);
    prdata_i  = $urandom;
    pslverr_i = 1'($urandom);

    for (int k = 0; k < n_acc; k++) begin
      @(negedge clk);
      chk("psel_access",  psel_o, 1);
      chk("pen_access",   penable_o, 1);
      chk("paddr_access", paddr_o, addr);
      chk("pwrite_access", pwrite_o, !rd);
      chk("pwdata_access", pwdata_o, wdata);
      chk("pstrb_access", pstrb_o, rd ? 4'h0 : be);
      chk("rvalid_access", data_r_valid_o, 0);
      chk("gnt_access",   data_gnt_o, 0);
      if (k == waits) begin
        pready_i  = 1'b1;
        prdata_i  = prd;
        pslverr_i = slv;
      end else begin
        pready_i  = 1'b0;
        prdata_i  = $urandom;
        pslverr_i = 1'($urandom);
      end
    end

    @(negedge clk);
    chk("rvalid_resp", data_r_valid_o, 1);
    chk("rdata_resp",  data_r_rdata_o, exp_rdata);
    chk("opc_resp",    data_r_opc_o, exp_opc);
    chk("psel_resp",   psel_o, 0);
    chk("pen_resp",    penable_o, 0);
    chk("gnt_resp",    data_gnt_o, 0);
    exp_pulses++;
    last_rdata = exp_rdata;
    last_opc   = exp_opc;
    data_req_i = hold;
    pready_i   = 1'b0;
  endtask

  initial begin
    rst_i        = 1'b1;
    data_req_i   = 1'b1;
    data_add_i   = 32'h5555_AAAA;
    data_wen_i   = 1'b0;
    data_wdata_i = 32'hFFFF_FFFF;
    data_be_i    = 4'hF;
    prdata_i     = 32'h0;
    pready_i     = 1'b1;
    pslverr_i    = 1'b0;

    // Reset state with a request pending: no grant, all outputs low.
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt",    data_gnt_o, 0);
    chk("rst_psel",   psel_o, 0);
    chk("rst_pen",    penable_o, 0);
    chk("rst_rvalid", data_r_valid_o, 0);
    chk("rst_rdata",  data_r_rdata_o, 0);
    chk("rst_opc",    data_r_opc_o, 0);
    chk("rst_paddr",  paddr_o, 0);
    chk("rst_pwdata", pwdata_o, 0);
    chk("rst_pwrite", pwrite_o, 0);
    chk("rst_pstrb",  pstrb_o, 0);
    rst_i      = 1'b0;
    data_req_i = 1'b0;

    // Directed cases.
    do_xfer(32'h1A30_0010, 1'b0, 32'h1234_5678, 4'hF, 0, 32'h0, 1'b0, 1'b0);
    do_xfer(32'h1A30_0020, 1'b1, 32'h0BAD_F00D, 4'hA, 3, 32'hCAFE_0001, 1'b0, 1'b0);
    do_xfer(32'h1A30_0030, 1'b1, 32'h0, 4'h3, 0, 32'h7777_0000, 1'b1, 1'b0);
    do_xfer(32'h1A30_0040, 1'b0, 32'hA5A5_5A5A, 4'h5, 1, 32'h0, 1'b0, 1'b1);
    do_xfer(32'h1A30_0044, 1'b1, 32'h0, 4'hC, 0, 32'h1357_9BDF, 1'b0, 1'b0);

    // Reset while in ACCESS.
    @(negedge clk);
    data_req_i   = 1'b1;
    data_add_i   = 32'h1A30_0050;
    data_wen_i   = 1'b1;
    data_be_i    = 4'hF;
    pready_i     = 1'b0;
    @(negedge clk);
    data_req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_psel", psel_o, 1);
    chk("pre_rst_pen",  penable_o, 1);
    rst_i      = 1'b1;
    data_req_i = 1'b1;
    #1;
    chk("midrst_gnt", data_gnt_o, 0);
    @(negedge clk);
    chk("midrst_psel",   psel_o, 0);
    chk("midrst_pen",    penable_o, 0);
    chk("midrst_rvalid", data_r_valid_o, 0);
    chk("midrst_gnt2",   data_gnt_o, 0);
    rst_i      = 1'b0;
    data_req_i = 1'b0;
    pready_i   = 1'b1;
    @(negedge clk);
    chk("postrst_rvalid", data_r_valid_o, 0);
    chk("postrst_psel",   psel_o, 0);
    last_rdata = 32'h0;
    last_opc   = 1'b0;
    do_xfer(32'h1A30_0060, 1'b1, 32'h0, 4'hF, 2, 32'h2468_ACE0, 1'b0, 1'b0);

    // Watchdog boundary: ready on the last allowed cycle, then hung slaves.
    do_xfer(32'h1A30_0070, 1'b1, 32'h0, 4'hF, TMO - 1, 32'h0F0F_0F0F, 1'b0, 1'b0);
    do_xfer(32'h1A30_0080, 1'b1, 32'h0, 4'hF, TMO + 12, 32'h1111_2222, 1'b0, 1'b0);
    do_xfer(32'h1A30_0090, 1'b0, 32'h3333_4444, 4'h6, TMO + 3, 32'h0, 1'b0, 1'b0);

    // Randomized transactions.
    for (int i = 0; i < 12; i++) begin
      do_xfer($urandom, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 5),
              $urandom, 1'($urandom), (i != 11) ? 1'($urandom) : 1'b0);
    end

    @(negedge clk);
    @(negedge clk);
    chk("pulse_count", n_pulses, exp_pulses);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
